// File: rtl/mcu_uart_pkg.sv
// mcu_uart_pkg: shared state encoding, UART defaults and round-robin search for the tx arbiter.
package mcu_uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;
  localparam int CLKS_PER_BIT_115200 = 434;
  localparam int UART_DATA_W = 8;
  function automatic logic [2:0] rr_next(logic [7:0] v, logic [2:0] ptr, int n);
    logic [2:0] r;
    logic [2:0] k;
    logic found;
    r = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = 3'((int'(ptr) + i) % n);
      if (i < n && !found && v[k]) begin
        r = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: baud-timed START/DATA/STOP framing of one byte, LSB first.
// UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_serializer import mcu_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [UART_DATA_W-1:0] data,
  output logic                   done,
  output logic                   tx
);
  tx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic tx_q, tx_d;
  logic wrap;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  always_comb begin
    wrap = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    state_d = state_q;
    cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        sh_d = data;
`ifdef UART_TX_PARITY_EN
        par_d = ^data;
`endif
      end
      START: if (wrap) state_d = DATA;
      DATA: if (wrap) begin
        bit_d = bit_q + 3'd1;
        sh_d = sh_q >> 1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (wrap) state_d = STOP;
`endif
      STOP: if (wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign done = state_q == STOP && wrap;
  assign tx = tx_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART tx line among NUM_REQ byte streams.
// Build with UART_TX_PARITY_EN for an 8E1 frame; default is 8N1.
module uart_tx_arbiter import mcu_uart_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_output,
  output logic                 busy,
  output logic [2:0]           grant_id
);
  tx_state_t state_q, state_d;
  logic [2:0] grant_q, grant_d, ptr_q, ptr_d;
  logic lock_q, lock_d, last_q, last_d, busy_q, busy_d;
  logic [7:0] v8, l8;
  logic [63:0] d64;
  logic accept, done;
  always_comb begin
    v8 = '0;
    l8 = '0;
    d64 = '0;
    v8[NUM_REQ-1:0] = req_valid;
    l8[NUM_REQ-1:0] = req_last;
    d64[NUM_REQ*8-1:0] = req_data;
    accept = state_q == LOAD && v8[grant_q];
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    lock_d = lock_q;
    last_d = last_q;
    // START here stands for "byte handed to the serializer, waiting for done"
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = rr_next(v8, ptr_q, NUM_REQ);
        state_d = LOAD;
      end
      LOAD: begin
        state_d = accept ? START : lock_q ? LOAD : IDLE;
        if (accept) begin
          lock_d = 1'b1;
          last_d = l8[grant_q];
        end
      end
      START: if (done) begin
        state_d = last_q ? IDLE : LOAD;
        lock_d = !last_q;
        if (last_q) ptr_d = grant_q == 3'(NUM_REQ - 1) ? 3'd0 : grant_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      lock_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      lock_q <= lock_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_ser (
    .clock(clock),
    .reset(reset),
    .start(accept),
    .data(d64[{grant_q, 3'b000} +: 8]),
    .done(done),
    .tx(uart_tx_output)
  );
  assign req_ready = accept ? NUM_REQ'(1) << grant_q : '0;
  assign busy = busy_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed requester streams, scoreboard of expected frames checked by a line monitor.
module tb_uart_tx_arbiter;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic tx, busy;
  logic [2:0] grant_id;
  int vectors = 0, miss = 0;
  logic [8:0] q0[$], q1[$];
  logic [10:0] exp_q[$];
  int rcount[2] = '{0, 0};

  uart_tx_arbiter #(.NUM_REQ(2), .CLKS_PER_BIT(4), .CNT_W(16)) dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_tx_output(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] frame_of(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // requester model: present queue heads, pop when the DUT accepted
  initial begin
    logic [1:0] rdy;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy[0] && q0.size() != 0) void'(q0.pop_front());
      if (rdy[1] && q1.size() != 0) void'(q1.pop_front());
      req_valid = {q1.size() != 0, q0.size() != 0};
      req_data = {q1.size() != 0 ? q1[0][7:0] : 8'h00, q0.size() != 0 ? q0[0][7:0] : 8'h00};
      req_last = {q1.size() != 0 ? q1[0][8] : 1'b0, q0.size() != 0 ? q0[0][8] : 1'b0};
    end
  end

  // line monitor and handshake rules
  logic act = 1'b0;
  int ph;
  logic [10:0] fr, e;
  logic [2:0] gid;
  logic [1:0] prev_rdy = '0;
  always @(negedge clk) begin
    if (req_ready != 0) begin
      chk("ready_onehot_granted", {30'd0, req_ready}, 32'd1 << grant_id);
      chk("ready_not_back_to_back", {30'd0, prev_rdy}, 32'd0);
      if (req_ready[0]) rcount[0]++;
      if (req_ready[1]) rcount[1]++;
    end
    prev_rdy = req_ready;
    if (rst) act = 1'b0;
    else if (!act) begin
      if (tx == 1'b0) begin
        act = 1'b1;
        ph = 0;
        fr = '0;
      end
    end else begin
      ph++;
      if (ph == 2) gid = grant_id;
      if (ph % 4 == 2) fr[ph / 4] = tx;
      if (ph == 4 * (FB - 1) + 2) begin
        act = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_frame", {21'd0, fr}, 32'hffff_ffff);
        else begin
          e = exp_q.pop_front();
          fr[10] = fr[10] & (FB == 11);
          chk("frame_bits", {21'd0, fr}, {21'd0, (FB == 11) ? frame_of(e[7:0]) : {1'b0, frame_of(e[7:0])} & 11'h3ff});
          chk("frame_grant_id", {29'd0, gid}, {29'd0, e[10:8]});
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(int id, logic [7:0] d, logic last, bit expect_frame);
    if (id == 0) q0.push_back({last, d});
    else q1.push_back({last, d});
    if (expect_frame) exp_q.push_back({3'(id), d});
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (!(busy == 1'b0 && q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !act) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_ready(int id, string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int bc;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset_idle", {26'd0, tx, busy, req_ready, grant_id}, {26'd0, 1'b1, 1'b0, 2'b00, 3'd0});
    end
    // single byte 0xA5: busy covers the LOAD cycle plus the 40-cycle frame
    send(0, 8'hA5, 1'b1, 1'b1);
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) bc++;
      else if (bc > 0) break;
    end
    chk("a5_busy_cycles", bc, 41);
    chk("a5_ready_count", rcount[0], 1);
    chk("a5_grant_id", {29'd0, grant_id}, 0);
    wait_idle("a5");
    // simultaneous single-byte packets alternate from pointer 0
    do_reset();
    send(0, 8'h3C, 1'b1, 1'b0);
    send(0, 8'hC3, 1'b1, 1'b0);
    send(1, 8'h81, 1'b1, 1'b0);
    send(1, 8'h18, 1'b1, 1'b0);
    exp_q.push_back({3'd0, 8'h3C});
    exp_q.push_back({3'd1, 8'h81});
    exp_q.push_back({3'd0, 8'hC3});
    exp_q.push_back({3'd1, 8'h18});
    wait_idle("rr");
    chk("rr_ready_count_0", rcount[0], 3);
    chk("rr_ready_count_1", rcount[1], 2);
    // locked 3-byte packet from requester 1 holds off a waiting requester 0
    send(1, 8'h11, 1'b0, 1'b1);
    send(1, 8'h22, 1'b0, 1'b1);
    send(1, 8'h33, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    send(0, 8'h5A, 1'b1, 1'b1);
    wait_idle("lock");
    chk("lock_ready_count_1", rcount[1], 5);
    // stall while locked: line idle high, lock held, requester 1 ignored
    send(0, 8'h55, 1'b0, 1'b1);
    wait_ready(0, "stall_accept");
    send(1, 8'h77, 1'b1, 1'b0);
    repeat (41) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      chk("stall_line", {29'd0, tx, busy, req_ready[1]}, {29'd0, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
    end
    chk("stall_no_ready_1", rcount[1], 5);
    chk("stall_grant_id", {29'd0, grant_id}, 0);
    exp_q.push_back({3'd0, 8'h66});
    exp_q.push_back({3'd1, 8'h77});
    send(0, 8'h66, 1'b1, 1'b0);
    wait_idle("stall");
    chk("stall_ready_count_1", rcount[1], 6);
    // reset during data bit 3 of 0x07
    send(1, 8'h07, 1'b1, 1'b0);
    wait_ready(1, "rst_accept");
    repeat (17) @(negedge clk);
    chk("rst_line_in_bit3", {31'd0, tx}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_line_next_cycle", {26'd0, tx, busy, req_ready, grant_id}, {26'd0, 1'b1, 1'b0, 2'b00, 3'd0});
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_quiet_after", {29'd0, tx, busy, act}, {29'd0, 1'b1, 1'b0, 1'b0});
    // full 0x07 frame after reset (parity bit 1 when enabled)
    send(0, 8'h07, 1'b1, 1'b1);
    wait_idle("p07");
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
